id_scoreboard: RTL

ID_SCOREBOARD -- requirements
Module: id_scoreboard

---
 rtl/id_scoreboard_if.sv | 33 +++
 rtl/id_scoreboard.sv | 77 +++++++
 2 files changed

// File: rtl/id_scoreboard_if.sv
// ID-stage scoreboard bus: decoded instruction, writeback retire and issue/stall results.
interface id_scoreboard_if;
    logic       i_valid;
    logic [2:0] i_rX;
    logic [2:0] i_rY;
    logic       i_use_rX;
    logic       i_use_rY;
    logic       i_wr_en;
    logic [2:0] i_rO;
    logic       i_halt;
    logic       i_flush;
    logic       i_wb_valid;
    logic [2:0] i_wb_rO;
    logic       o_issue;
    logic       o_stall;
    logic       o_halted;
    logic       o_drained;
    logic       o_err;

    // Pipeline side: drives the instruction and retire, observes the decision.
    modport master (
        output i_valid, i_rX, i_rY, i_use_rX, i_use_rY, i_wr_en, i_rO, i_halt, i_flush,
               i_wb_valid, i_wb_rO,
        input  o_issue, o_stall, o_halted, o_drained, o_err
    );

    // Scoreboard side.
    modport slave (
        input  i_valid, i_rX, i_rY, i_use_rX, i_use_rY, i_wr_en, i_rO, i_halt, i_flush,
               i_wb_valid, i_wb_rO,
        output o_issue, o_stall, o_halted, o_drained, o_err
    );
endinterface

// File: rtl/id_scoreboard.sv
// Per-register pending-write scoreboard for an in-order ID stage. Tracks in-flight writes
// to r0..r7, stalls on RAW hazards and counter saturation, and latches HALT and
// retire-underflow errors.
module id_scoreboard #(
    parameter int unsigned CNT_W = 2
) (
    input logic           clk,
    input logic           rst,
    id_scoreboard_if.slave bus
);

    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_q [8];
    logic [CNT_W-1:0] cnt_d [8];
    logic             halted_q, halted_d;
    logic             err_q, err_d;
    logic             hazard;
    logic             issue;
    logic             inc, dec;

    // Hazard check uses pre-edge counts only; a same-cycle retire does not bypass.
    always_comb begin
        hazard = (bus.i_use_rX && (cnt_q[bus.i_rX] != '0)) ||
                 (bus.i_use_rY && (cnt_q[bus.i_rY] != '0)) ||
                 (bus.i_wr_en  && (cnt_q[bus.i_rO] == CntMax));
        issue  = bus.i_valid && !bus.i_flush && !halted_q && !hazard;
    end

    // Next-state: counter inc on issued write, dec on retire; same-register pair cancels.
    always_comb begin
        inc      = issue && bus.i_wr_en;
        dec      = bus.i_wb_valid && (cnt_q[bus.i_wb_rO] != '0);
        halted_d = halted_q || (issue && bus.i_halt);
        err_d    = err_q || (bus.i_wb_valid && (cnt_q[bus.i_wb_rO] == '0));
        for (int r = 0; r < 8; r++) begin
            cnt_d[r] = cnt_q[r];
            if (inc && (bus.i_rO == 3'(r)) && !(dec && (bus.i_wb_rO == 3'(r)))) begin
                cnt_d[r] = cnt_q[r] + 1'b1;
            end else if (dec && (bus.i_wb_rO == 3'(r)) && !(inc && (bus.i_rO == 3'(r)))) begin
                cnt_d[r] = cnt_q[r] - 1'b1;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 8; r++) begin
                cnt_q[r] <= '0;
            end
            halted_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            for (int r = 0; r < 8; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            halted_q <= halted_d;
            err_q    <= err_d;
        end
    end

    // Outputs: issue/stall from inputs and state, status flags from state.
    always_comb begin
        bus.o_issue   = issue;
        bus.o_stall   = bus.i_valid && !bus.i_flush && (halted_q || hazard);
        bus.o_halted  = halted_q;
        bus.o_err     = err_q;
        bus.o_drained = 1'b1;
        for (int r = 0; r < 8; r++) begin
            if (cnt_q[r] != '0) begin
                bus.o_drained = 1'b0;
            end
        end
    end

endmodule
